// File: rtl/qif_pkg.sv
`default_nettype none
// ============================================================================
// Package     : qif_pkg
// Description : Default widths and a saturating-increment helper for the
//               QIF spike monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package qif_pkg;

    localparam int ISI_W_DEF      = 16;
    localparam int CNT_W_DEF      = 8;
    localparam int WIN_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    // Increment, holding at the all-ones value of a WIDTH-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_v;
        max_v = (32'd1 << width) - 32'd1;
        return (val >= max_v) ? max_v : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qif_isi_fifo.sv
`default_nettype none
// ============================================================================
// Module      : qif_isi_fifo
// Description : First-word-fall-through synchronous FIFO for ISI samples.
// Revision    : 1.0 - initial release
// ============================================================================
module qif_isi_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] c_ptr_one   = AW'(1);
    localparam logic [AW:0]   c_cnt_one   = (AW + 1)'(1);
    localparam logic [AW:0]   c_cnt_depth = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             w_pop;
    logic             w_push;

    assign full  = (count_q == c_cnt_depth);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the head is leaving.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module      : qif_spike_monitor
// Description : Spike edge detector, inter-spike-interval FIFO and windowed
//               spike-rate counter for the QIF neuron output.
// Revision    : 1.0 - initial release
// ============================================================================
module qif_spike_monitor
    import qif_pkg::*;
#(
    parameter int ISI_W      = ISI_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             clr_ovf,
    output logic             spike_edge,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_data,
    output logic             isi_valid,
    input  logic             isi_ready,
    output logic             overflow
);

    localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);
    localparam logic [ISI_W-1:0] c_isi_one = ISI_W'(1);

    logic             spike_q,      spike_d;
    logic             spike_edge_q, spike_edge_d;
    logic             armed_q,      armed_d;
    logic [ISI_W-1:0] isi_cnt_q,    isi_cnt_d;
    logic [WIN_W-1:0] win_lat_q,    win_lat_d;
    logic [WIN_W-1:0] win_cnt_q,    win_cnt_d;
    logic [CNT_W-1:0] spike_cnt_q,  spike_cnt_d;
    logic [CNT_W-1:0] rate_out_q,   rate_out_d;
    logic             rate_valid_q, rate_valid_d;
    logic             overflow_q,   overflow_d;

    logic             w_edge;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_idle;
    logic             w_last;
    logic [CNT_W-1:0] w_spk_inc;

    assign w_edge = spike_in & ~spike_q & ena;
    assign w_push = w_edge & armed_q;
    // Full implies non-empty, so a ready consumer always frees the slot.
    assign w_drop = w_push & w_full & ~isi_ready;

    // Edge detector and ISI counter
    always_comb begin
        spike_d      = spike_in;
        spike_edge_d = w_edge;
        armed_d      = armed_q | w_edge;
        isi_cnt_d    = isi_cnt_q;
        if (w_edge) begin
            isi_cnt_d = c_isi_one;
        end else if (armed_q && ena) begin
            isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), ISI_W));
        end
        overflow_d = w_drop | (overflow_q & ~clr_ovf);
    end

    // Window: win_lat == 0 means idle; win_len is sampled whenever a new
    // window is about to begin, including every idle cycle.
    assign w_idle    = (win_lat_q == '0);
    assign w_last    = ~w_idle & ena & (win_cnt_q == (win_lat_q - c_win_one));
    assign w_spk_inc = w_edge ? CNT_W'(sat_inc(32'(spike_cnt_q), CNT_W)) : spike_cnt_q;

    always_comb begin
        win_lat_d    = win_lat_q;
        win_cnt_d    = win_cnt_q;
        spike_cnt_d  = spike_cnt_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = 1'b0;
        if (w_idle) begin
            win_lat_d   = win_len;
            win_cnt_d   = '0;
            spike_cnt_d = '0;
        end else if (w_last) begin
            rate_out_d   = w_spk_inc;
            rate_valid_d = 1'b1;
            spike_cnt_d  = '0;
            win_cnt_d    = '0;
            win_lat_d    = win_len;
        end else if (ena) begin
            win_cnt_d   = win_cnt_q + c_win_one;
            spike_cnt_d = w_spk_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q      <= 1'b0;
            spike_edge_q <= 1'b0;
            armed_q      <= 1'b0;
            isi_cnt_q    <= '0;
            win_lat_q    <= '0;
            win_cnt_q    <= '0;
            spike_cnt_q  <= '0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            spike_q      <= spike_d;
            spike_edge_q <= spike_edge_d;
            armed_q      <= armed_d;
            isi_cnt_q    <= isi_cnt_d;
            win_lat_q    <= win_lat_d;
            win_cnt_q    <= win_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    qif_isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_isi_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (isi_cnt_q),
        .pop   (isi_ready),
        .full  (w_full),
        .empty (w_empty),
        .rdata (isi_data)
    );

    assign spike_edge = spike_edge_q;
    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign isi_valid  = ~w_empty;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_qif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_qif_spike_monitor
// Description : Scoreboard bench for qif_spike_monitor against an
//               event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qif_spike_monitor;

    localparam int ISI_W = 16;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int DEPTH = 4;
    localparam int ISI_MAX = 65535;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             spike_in;
    logic [WIN_W-1:0] win_len;
    logic             clr_ovf;
    logic             spike_edge;
    logic [CNT_W-1:0] rate_out;
    logic             rate_valid;
    logic [ISI_W-1:0] isi_data;
    logic             isi_valid;
    logic             isi_ready;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    // Expected {spike_edge, overflow, isi_valid, rate_valid, rate_out} per cycle
    logic [CNT_W+3:0] exp_q[$];
    logic [ISI_W-1:0] sb_isi[$];

    // Reference model state
    bit m_prev, m_armed, m_ovf, m_rv;
    int m_since, m_wlen, m_wpos, m_spk, m_rate;
    int m_fifo[$];

    qif_spike_monitor #(
        .ISI_W      (ISI_W),
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .clr_ovf    (clr_ovf),
        .spike_edge (spike_edge),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .isi_data   (isi_data),
        .isi_valid  (isi_valid),
        .isi_ready  (isi_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        logic [CNT_W+3:0] act;
        logic [CNT_W+3:0] e;
        act = {spike_edge, overflow, isi_valid, rate_valid, rate_out};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("status{edge,ovf,isi_valid,rate_valid,rate}", act, e);
        end
        if (rst_n && isi_valid && isi_ready) begin
            if (sb_isi.size() == 0) begin
                total++;
                bad++;
                $display("FAIL isi_pop: got 0x%0h with nothing expected at %0t", isi_data, $time);
            end else begin
                check("isi_data", isi_data, sb_isi.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_prev = 0; m_armed = 0; m_ovf = 0; m_rv = 0;
        m_since = 0; m_wlen = 0; m_wpos = 0; m_spk = 0; m_rate = 0;
        m_fifo.delete();
        sb_isi.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic step();
        bit e, pop;
        int isi;
        e      = spike_in && !m_prev && ena;
        m_prev = spike_in;

        pop = isi_ready && (m_fifo.size() > 0);
        if (pop) void'(m_fifo.pop_front());
        if (clr_ovf) m_ovf = 0;
        if (e && m_armed) begin
            isi = (m_since + 1 > ISI_MAX) ? ISI_MAX : m_since + 1;
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(isi);
                sb_isi.push_back(ISI_W'(isi));
            end else begin
                m_ovf = 1;
            end
        end
        if (e) begin
            m_armed = 1;
            m_since = 0;
        end else if (ena && m_armed && m_since < 100000) begin
            m_since++;
        end

        m_rv = 0;
        if (m_wlen == 0) begin
            m_spk  = 0;
            m_wpos = 0;
            m_wlen = int'(win_len);
        end else if (ena) begin
            m_spk  += int'(e);
            m_wpos++;
            if (m_wpos == m_wlen) begin
                m_rate = (m_spk > CNT_MAX) ? CNT_MAX : m_spk;
                m_rv   = 1;
                m_spk  = 0;
                m_wpos = 0;
                m_wlen = int'(win_len);
            end
        end
        exp_q.push_back({e, m_ovf, (m_fifo.size() > 0), m_rv, CNT_W'(m_rate)});
    endtask

    task automatic cyc();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // One-cycle spike, next call's edge lands exactly gap cycles later.
    task automatic pulse(input int gap);
        spike_in = 1'b1;
        cyc();
        spike_in = 1'b0;
        if (gap > 1) run(gap - 1);
    endtask

    task automatic hold_reset(input int n);
        rst_n    = 1'b0;
        spike_in = 1'b0;
        model_reset();
        repeat (n) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded 5000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int pos_list[5];
        bit hit;
        pos_list = '{2, 6, 10, 15, 19};

        // Reset held with spike high; ena low on the release cycle.
        rst_n = 1'b0; ena = 1'b0; spike_in = 1'b1; clr_ovf = 1'b0;
        isi_ready = 1'b0; win_len = '0;
        model_reset();
        repeat (3) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
        end
        spike_in = 1'b1;
        rst_n = 1'b1;
        cyc();
        ena = 1'b1;
        run(3);
        spike_in = 1'b0;
        run(2);

        // ISIs 7 and 10; the first edge only arms.
        pulse(7);
        pulse(10);
        pulse(5);
        isi_ready = 1'b1;
        run(4);

        // Window of 20 with five spikes, one on the closing cycle.
        win_len = 16'd20;
        guard = 0;
        while (!(m_wlen == 20 && m_wpos == 0) && guard < 60) begin
            cyc();
            guard++;
        end
        check("window_align_within_budget", guard < 60, 1);
        for (int p = 0; p < 20; p++) begin
            hit = 0;
            foreach (pos_list[k]) if (pos_list[k] == p) hit = 1;
            spike_in = hit;
            cyc();
        end
        spike_in = 1'b0;
        run(25);

        // Overflow: six ISIs into a stalled FIFO, clear, full push+pop, drain.
        win_len = '0;
        isi_ready = 1'b1;
        run(3);
        isi_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(3 + i);
        run(2);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        run(2);
        spike_in = 1'b1;
        isi_ready = 1'b1;
        cyc();
        spike_in = 1'b0;
        isi_ready = 1'b0;
        run(3);
        isi_ready = 1'b1;
        run(8);

        // Saturated ISI, then an interval with ena low for 3 cycles.
        pulse(70000);
        pulse(5);
        ena = 1'b0;
        run(3);
        ena = 1'b1;
        run(2);
        pulse(4);
        run(3);

        // Randomized phase: stalled consumer first, then a mostly ready one.
        for (int i = 0; i < 2000; i++) begin
            spike_in  = ($urandom_range(0, 3) == 0);
            ena       = ($urandom_range(0, 7) != 0);
            isi_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) win_len = WIN_W'($urandom_range(0, 12));
            cyc();
        end
        clr_ovf = 1'b0;
        ena = 1'b1;

        // Reset in the middle of a window with ISIs queued.
        win_len = 16'd15;
        isi_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spike_in = (i % 3 == 0);
            cyc();
        end
        #5;
        hold_reset(2);
        run(5);

        // Final drain and scoreboard emptiness.
        spike_in = 1'b0;
        isi_ready = 1'b1;
        run(10);
        @(negedge clk);
        #1;
        check("isi_scoreboard_left", sb_isi.size(), 0);
        check("status_queue_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
